alu_seq_core: RTL and testbench

//  Parametrised, clocked successor to the 8-bit combinational ALU/CU: 3-bit opcode plus two WIDTH-bit operands.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 60 ++++++
 rtl/alu_seq_core.sv | 145 ++++++++++++++
 tb/tb_alu_seq_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core: opcodes, flag bit indices
// and the controller state encoding.
package alu_pkg;

  // Opcode encoding (3 bits)
  localparam logic [2:0] OP_MUL = 3'b000;  // MUL, or NOP when multiply is disabled
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Bit positions inside the 4-bit flag vector {zero, carry, neg, ovf}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  // Controller states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts a multiply)
//   start         load operands and begin WIDTH iterations
//   a, b          multiplicand, multiplier (sampled on start)
//   done_c        high during the last iteration cycle (combinational)
//   product_c     full 2*WIDTH product, valid while done_c is high
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [PW-1:0]    addend;

  // Partial product for the current multiplier bit; the final one is folded
  // in combinationally so the product is ready on the last iteration edge.
  assign addend    = mplier[0] ? mcand : '0;
  assign product_c = acc + addend;
  assign done_c    = active && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
      acc    <= '0;
    end else if (active) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done_c) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU core with valid/ready handshakes, registered result and flags,
// and an optional iterative multiply on opcode 000.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake (in_op, in_a, in_b)
//   out_valid/out_ready      result handshake (out_result, out_flags)
//   out_flags                {zero, carry, neg, ovf}
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam int unsigned SW = WIDTH + 1;

  state_t             state;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_cin;
  logic [SW-1:0]      sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_flags;

  // Handshake: accept only when idle and the output slot is free or draining.
  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (in_op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_mul),
    .a         (in_a),
    .b         (in_b),
    .done_c    (mul_done),
    .product_c (mul_prod)
  );

  // Operand steering for the single shared adder.
  always_comb begin
    add_x   = in_a;
    add_y   = '0;
    add_cin = 1'b0;
    case (in_op)
      OP_ADD: add_y = in_b;
      OP_SUB: begin
        add_y   = ~in_b;
        add_cin = 1'b1;
      end
      OP_INC: add_cin = 1'b1;
      OP_DEC: add_y = '1;
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + SW'(add_cin);
  // Signed overflow: like-signed adder inputs producing a differently-signed sum.
  assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  // Single-cycle result and flags.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (in_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_V] = add_ovf;
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_NOT:  alu_res = ~in_a;
      default: ;
    endcase
    // NOP leaves all flags clear.
    if (in_op != OP_MUL) begin
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
    end
  end

  // Multiply flags: carry marks a product that does not fit in WIDTH bits.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
  end

  // Controller and output registers; a load on the drain edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_BUSY;
            end else begin
              out_valid  <= 1'b1;
              out_result <= alu_res;
              out_flags  <= alu_flags;
            end
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b1;
            out_result <= mul_prod[WIDTH-1:0];
            out_flags  <= mul_flags;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8, MUL_EN=1).
module tb_alu_seq_core;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  int checks   = 0;
  int failures = 0;

  alu_seq_core #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {zero, carry, neg, ovf, result} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int ua, ub, sa, sb, r, sr;
    logic c, v, z, n;
    logic [W-1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin r = ua * ub; c = (r > 255); end
      3'd1: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      3'd2: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      3'd3: begin r = ua + 1;  c = (r > 255); sr = sa + 1;  v = (sr > 127); end
      3'd4: begin r = ua - 1;  c = (ua != 0); sr = sa - 1;  v = (sr < -128); end
      3'd5: r = ua & ub;
      3'd6: r = ua | ub;
      default: r = 255 - ua;
    endcase
    res = W'(r);
    z = (res == 0);
    n = res[W-1];
    return {z, c, n, v, res};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  // Issue one op with out_ready low, check latency/busy behaviour, result and
  // flags, then drain it.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [11:0] exp, input string tag);
    wait_ready(tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    in_op = 3'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    if (op == 3'd0) begin
      for (int k = 0; k < W; k++) begin
        chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy_vld"}, 32'(out_valid), 32'd0);
        in_op = 3'($urandom); in_a = W'($urandom); in_b = W'($urandom);
        tick();
      end
    end
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(out_result), 32'(exp[7:0]));
    chk({tag, "_flg"}, 32'(out_flags), 32'(exp[11:8]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick();
    chk("rst_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_result), 32'd0);
    chk("rst_flg", 32'(out_flags), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // Directed cases, expected {z,c,n,v,result}
    do_op(3'd1, 8'hF0, 8'h20, {4'b0100, 8'h10}, "add_f0_20");
    do_op(3'd2, 8'h05, 8'h07, {4'b0010, 8'hFE}, "sub_05_07");
    do_op(3'd2, 8'h80, 8'h01, {4'b0101, 8'h7F}, "sub_80_01");
    do_op(3'd2, 8'h33, 8'h33, {4'b1100, 8'h00}, "sub_33_33");
    do_op(3'd3, 8'h7F, 8'h00, {4'b0011, 8'h80}, "inc_7f");
    do_op(3'd4, 8'h00, 8'h55, {4'b0010, 8'hFF}, "dec_00");
    do_op(3'd4, 8'h01, 8'hAA, {4'b1100, 8'h00}, "dec_01");
    do_op(3'd0, 8'h0D, 8'h0B, {4'b0010, 8'h8F}, "mul_0d_0b");
    do_op(3'd0, 8'h10, 8'h10, {4'b1100, 8'h00}, "mul_10_10");
    do_op(3'd7, 8'h0F, 8'h00, {4'b0010, 8'hF0}, "not_0f");

    // Backpressure: result held while out_ready is low
    wait_ready("bp");
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'h01; in_b = 8'h02;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_res", 32'(out_result), 32'h03);
      tick();
    end
    // Drain and accept on the same edge, then back-to-back
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd1; in_a = 8'h10; in_b = 8'h20;
    #1;
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    tick();
    chk("b2b_vld0", 32'(out_valid), 32'd1);
    chk("b2b_res0", 32'(out_result), 32'h30);
    in_a = 8'h05; in_b = 8'h06;
    tick();
    chk("b2b_vld1", 32'(out_valid), 32'd1);
    chk("b2b_res1", 32'(out_result), 32'h0B);
    in_a = 8'h7F; in_b = 8'h01;
    tick();
    chk("b2b_res2", 32'(out_result), 32'h80);
    chk("b2b_flg2", 32'(out_flags), 32'b0011);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset during the 3rd BUSY cycle of a multiply
    wait_ready("rstmul");
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'h0D; in_b = 8'h0B;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstmul_vld", 32'(out_valid), 32'd0);
    chk("rstmul_res", 32'(out_result), 32'd0);
    chk("rstmul_flg", 32'(out_flags), 32'd0);
    chk("rstmul_rdy_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmul_rdy", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("rstmul_aborted", 32'(out_valid), 32'd0);
    do_op(3'd5, 8'hF0, 8'h3C, {4'b0000, 8'h30}, "and_f0_3c");

    // Randomised ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (i < 6) ra = (i % 2 == 0) ? 8'h00 : 8'hFF;
      do_op(rop, ra, rb, model(rop, ra, rb), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
